im_loader: RTL and testbench
============================

IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter DataSize, default 32, instruction word width.
REQ-002 Parameter MemSize, default 10, IM address width (depth 2^MemSize).
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; begins clear+load sequence.
REQ-006 in_valid / in_data / in_last  input  1 / DataSize / 1  program word stream from host; in_last marks final word.
REQ-007 in_ready  output  1  loader accepts a word on a cycle where in_valid and in_ready are both high.
REQ-008 cpu_PC / cpu_IM_read / cpu_IM_enable  input  MemSize / 1 / 1  CPU fetch port, passed through in RUN.
REQ-009 PC / IM_read / IM_write / IM_enable / IMin  output  MemSize / 1 / 1 / 1 / DataSize  IM port: IM_address, enable_fetch, enable_write, enable_im, IMin.
REQ-010 cpu_reset  output  1  drives CPU top reset; high except in RUN.
REQ-011 load_done / load_err  output  1 / 1  status flags.
REQ-012 word_count  output  MemSize+1  number of words accepted in current load.

Function
REQ-013 States: IDLE, CLEAR, LOAD, FLUSH, RUN, ERROR.
REQ-014 IDLE: in_ready=0, IM_write=0, IM_enable=0; start -> CLEAR with wr_ptr=0.
REQ-015 CLEAR: one write per cycle, IMin=0, PC=wr_ptr, IM_write=1, IM_enable=1, IM_read=0; after address 2^MemSize-1 is written -> LOAD, wr_ptr=0.
REQ-016 LOAD: in_ready=1; each accepted word is registered and presented next cycle as PC=wr_ptr, IMin=in_data, IM_write=1, IM_enable=1; wr_ptr and word_count increment by 1; throughput one word per cycle.
REQ-017 Cycles in LOAD with no handshake: IM_write=0, IM_enable=0.
REQ-018 Word accepted with in_last=1 -> FLUSH; in_ready=0 in FLUSH; FLUSH lasts one cycle (final write completes), then -> RUN.
REQ-019 Word accepted at wr_ptr=2^MemSize-1 with in_last=0 -> ERROR after that write; load_err=1; further words not accepted.
REQ-020 RUN: cpu_reset=0, load_done=1, in_ready=0; PC/IM_read/IM_enable follow cpu_* combinationally, IM_write=0, IMin=0.
REQ-021 start in RUN or ERROR -> CLEAR; cpu_reset=1 and load_done=0, load_err=0, word_count=0 from next cycle.
REQ-022 start in CLEAR, LOAD or FLUSH ignored.
REQ-023 cpu_reset high in every state other than RUN; it deasserts exactly one cycle after FLUSH.
REQ-024 in_valid high outside LOAD never alters state or IM.
REQ-025 wr_ptr is MemSize bits; never wraps within one load (ERROR catches overflow).

Reset
REQ-026 reset -> IDLE, wr_ptr=0, word_count=0, in_ready=0, IM_write=0, IM_read=0, IM_enable=0, PC=0, IMin=0, cpu_reset=1, load_done=0, load_err=0.
REQ-027 reset mid-CLEAR/LOAD aborts the sequence; IM contents already written are left unchanged.
REQ-028 reset has priority over start and handshake in the same cycle.

Structure
REQ-029 Shared package im_loader_pkg holds state encoding, DataSize/MemSize defaults, and IM depth constant.
REQ-030 Single module, no sub-modules; port mux for RUN lives in im_loader.

Verification
REQ-031 reset, start, 3 words 0x11,0x22,0x33(last) -> IM[0..2]=0x11,0x22,0x33, IM[3..1023]=0, word_count=3, cpu_reset falls 1 cycle after FLUSH.
REQ-032 Stream with in_valid toggling every other cycle, 5 words -> IM[0..4] correct, no write on idle cycles, word_count=5.
REQ-033 1024 words, none marked last -> all written, load_err=1, cpu_reset stays 1, in_ready=0 thereafter.
REQ-034 In RUN, cpu_PC=0x005, cpu_IM_read=1 -> PC=0x005, IM_read=1, IM_write=0, instruction from IM[5] on IMout.
REQ-035 reset asserted after 2 of 4 words -> IDLE, cpu_reset=1, IM[0..1] hold loaded values, new start reloads cleanly.
REQ-036 start pulse in RUN -> CLEAR next cycle, cpu_reset=1, load_done=0, IM fully zeroed before LOAD.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The state type is shared so that other blocks decode the loader state the same way.
package im_loader_pkg;

  localparam int unsigned DATA_SIZE = 32;
  localparam int unsigned MEM_SIZE  = 10;
  localparam int unsigned IM_DEPTH  = 1 << MEM_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/im_loader_if.sv
// Host-side program stream: the start pulse plus the valid/ready word channel.
// The loader sits on the slave side of this channel.
interface im_loader_if #(
  parameter int unsigned DataSize = im_loader_pkg::DATA_SIZE
) ();

  logic                start;
  logic                in_valid;
  logic [DataSize-1:0] in_data;
  logic                in_last;
  logic                in_ready;

  modport master (
    output start,
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  start,
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/im_loader.sv
// Clears the instruction memory, streams a program into it from the host, then
// releases the CPU and hands the IM port to the CPU fetch path.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned DataSize = DATA_SIZE,
  parameter int unsigned MemSize  = MEM_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  im_loader_if.slave          host,
  input  logic [MemSize-1:0]  cpu_PC,
  input  logic                cpu_IM_read,
  input  logic                cpu_IM_enable,
  output logic [MemSize-1:0]  PC,
  output logic                IM_read,
  output logic                IM_write,
  output logic                IM_enable,
  output logic [DataSize-1:0] IMin,
  output logic                cpu_reset,
  output logic                load_done,
  output logic                load_err,
  output logic [MemSize:0]    word_count
);

  localparam logic [MemSize-1:0] LastAddr = '1;

  state_t              r_state;
  logic [MemSize-1:0]  r_wr_ptr;
  logic [MemSize:0]    r_word_count;
  logic                r_in_ready;
  logic [MemSize-1:0]  r_PC;
  logic                r_IM_write;
  logic                r_IM_enable;
  logic [DataSize-1:0] r_IMin;
  logic                r_cpu_reset;
  logic                r_load_done;
  logic                r_load_err;

  logic w_accept;
  logic w_run;
  logic w_at_last;

  // r_in_ready is only ever high in LOAD, so it also qualifies the handshake
  assign w_accept  = r_in_ready & host.in_valid;
  assign w_run     = (r_state == ST_RUN);
  assign w_at_last = (r_wr_ptr == LastAddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_in_ready   <= 1'b0;
      r_PC         <= '0;
      r_IM_write   <= 1'b0;
      r_IM_enable  <= 1'b0;
      r_IMin       <= '0;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      // IM strobes are single-cycle; each state re-asserts them when it writes
      r_IM_write  <= 1'b0;
      r_IM_enable <= 1'b0;
      r_IMin      <= '0;

      unique case (r_state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (host.start) begin
            r_state      <= ST_CLEAR;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_in_ready   <= 1'b0;
            r_PC         <= '0;
            r_IM_write   <= 1'b1;
            r_IM_enable  <= 1'b1;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
          end
        end

        ST_CLEAR: begin
          // PC always shows the address being zeroed this cycle
          if (w_at_last) begin
            r_state    <= ST_LOAD;
            r_wr_ptr   <= '0;
            r_in_ready <= 1'b1;
          end else begin
            r_wr_ptr    <= r_wr_ptr + MemSize'(1);
            r_PC        <= r_wr_ptr + MemSize'(1);
            r_IM_write  <= 1'b1;
            r_IM_enable <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (w_accept) begin
            r_PC         <= r_wr_ptr;
            r_IMin       <= host.in_data;
            r_IM_write   <= 1'b1;
            r_IM_enable  <= 1'b1;
            r_word_count <= r_word_count + (MemSize + 1)'(1);
            if (!w_at_last) begin
              r_wr_ptr <= r_wr_ptr + MemSize'(1);
            end
            if (host.in_last) begin
              r_state    <= ST_FLUSH;
              r_in_ready <= 1'b0;
            end else if (w_at_last) begin
              r_state    <= ST_ERROR;
              r_in_ready <= 1'b0;
              r_load_err <= 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          // final word is being written this cycle; CPU comes out of reset next
          r_state     <= ST_RUN;
          r_PC        <= '0;
          r_cpu_reset <= 1'b0;
          r_load_done <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // In RUN the CPU fetch port drives the IM directly
  assign PC         = w_run ? cpu_PC        : r_PC;
  assign IM_read    = w_run ? cpu_IM_read   : 1'b0;
  assign IM_enable  = w_run ? cpu_IM_enable : r_IM_enable;
  assign IM_write   = r_IM_write;
  assign IMin       = r_IMin;

  assign host.in_ready = r_in_ready;
  assign cpu_reset     = r_cpu_reset;
  assign load_done     = r_load_done;
  assign load_err      = r_load_err;
  assign word_count    = r_word_count;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: an IM model, a write scoreboard and
// directed load / run / overflow / reset-abort sequences.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int unsigned DW    = DATA_SIZE;
  localparam int unsigned MW    = MEM_SIZE;
  localparam int unsigned DEPTH = IM_DEPTH;

  typedef struct packed {
    logic [MW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [MW-1:0] cpu_PC;
  logic          cpu_IM_read;
  logic          cpu_IM_enable;
  logic [MW-1:0] PC;
  logic          IM_read;
  logic          IM_write;
  logic          IM_enable;
  logic [DW-1:0] IMin;
  logic          cpu_reset;
  logic          load_done;
  logic          load_err;
  logic [MW:0]   word_count;

  im_loader_if #(.DataSize(DW)) host ();

  im_loader #(.DataSize(DW), .MemSize(MW)) dut (
    .clk           (clk),
    .reset         (reset),
    .host          (host),
    .cpu_PC        (cpu_PC),
    .cpu_IM_read   (cpu_IM_read),
    .cpu_IM_enable (cpu_IM_enable),
    .PC            (PC),
    .IM_read       (IM_read),
    .IM_write      (IM_write),
    .IM_enable     (IM_enable),
    .IMin          (IMin),
    .cpu_reset     (cpu_reset),
    .load_done     (load_done),
    .load_err      (load_err),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] im      [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] im_out;
  logic          tb_fill;
  wr_t           sb [$];
  int            exp_ptr;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;

  // Instruction memory model, pre-filled with junk so clearing is observable
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_fill) begin
      for (int i = 0; i < int'(DEPTH); i++) im[i] <= DW'(32'hDEAD0000 | i);
    end else if (IM_write && IM_enable) begin
      im[PC] <= IMin;
    end
  end

  assign im_out = (IM_enable && IM_read) ? im[PC] : '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load writes are those seen while word_count is non-zero
  always @(negedge clk) begin
    if (IM_write && IM_enable && word_count != '0) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(PC), 64'(e.addr));
        chk("wr_data", 64'(IMin), 64'(e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 host.start = 1'b1;
    @(posedge clk);
    #1 host.start = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
    exp_ptr = 0;
  endtask

  task automatic mem_check(input string tag);
    int bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (im[i] !== exp_mem[i]) bad++;
    chk(tag, 64'(bad), 64'(0));
  endtask

  task automatic wait_ready();
    int budget = 3000;
    while (!host.in_ready && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("wait_ready", 64'(host.in_ready), 64'(1));
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    int budget = 3000;
    host.in_valid = 1'b1;
    host.in_data  = d;
    host.in_last  = last;
    while (!host.in_ready && budget > 0) begin
      tick(1);
      budget--;
    end
    if (!host.in_ready) begin
      chk("ready_timeout", 64'(host.in_ready), 64'(1));
      host.in_valid = 1'b0;
      return;
    end
    sb.push_back(wr_t'{addr: MW'(exp_ptr), data: d});
    exp_mem[exp_ptr] = d;
    exp_ptr++;
    tick(1);
    host.in_valid = 1'b0;
    host.in_last  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    reset         = 1'b1;
    tb_fill       = 1'b1;
    host.start    = 1'b0;
    host.in_valid = 1'b0;
    host.in_data  = '0;
    host.in_last  = 1'b0;
    cpu_PC        = '0;
    cpu_IM_read   = 1'b0;
    cpu_IM_enable = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = DW'(32'hDEAD0000 | i);
    exp_ptr = 0;
    tick(1);
    tb_fill = 1'b0;
    tick(1);
    reset = 1'b0;

    chk("rst_in_ready",  64'(host.in_ready), 64'(0));
    chk("rst_IM_write",  64'(IM_write),      64'(0));
    chk("rst_IM_read",   64'(IM_read),       64'(0));
    chk("rst_IM_enable", 64'(IM_enable),     64'(0));
    chk("rst_PC",        64'(PC),            64'(0));
    chk("rst_IMin",      64'(IMin),          64'(0));
    chk("rst_cpu_reset", 64'(cpu_reset),     64'(1));
    chk("rst_load_done", 64'(load_done),     64'(0));
    chk("rst_load_err",  64'(load_err),      64'(0));
    chk("rst_word_count",64'(word_count),    64'(0));

    // reset wins over a simultaneous start
    host.start = 1'b1;
    reset      = 1'b1;
    tick(1);
    host.start = 1'b0;
    reset      = 1'b0;
    chk("rst_prio_we", 64'(IM_write), 64'(0));
    tick(1);
    chk("rst_prio_idle_we", 64'(IM_write), 64'(0));
    mem_check("im_untouched");

    // three-word program
    pulse_start();
    clear_exp();
    chk("clr_cpu_reset", 64'(cpu_reset), 64'(1));
    chk("clr_we",        64'(IM_write),  64'(1));
    chk("clr_pc",        64'(PC),        64'(0));
    send_word(DW'(32'h11), 1'b0);
    send_word(DW'(32'h22), 1'b0);
    send_word(DW'(32'h33), 1'b1);
    chk("flush_ready",     64'(host.in_ready), 64'(0));
    chk("flush_cpu_reset", 64'(cpu_reset),     64'(1));
    chk("flush_we",        64'(IM_write),      64'(1));
    chk("flush_pc",        64'(PC),            64'(2));
    tick(1);
    chk("run_cpu_reset",  64'(cpu_reset),      64'(0));
    chk("run_load_done",  64'(load_done),      64'(1));
    chk("run_word_count", 64'(word_count),     64'(3));
    chk("run_ready",      64'(host.in_ready),  64'(0));
    mem_check("im_prog3");

    // CPU fetch pass-through
    cpu_PC = MW'(2); cpu_IM_read = 1'b1; cpu_IM_enable = 1'b1;
    #1;
    chk("run_pc",      64'(PC),       64'(2));
    chk("run_im_read", 64'(IM_read),  64'(1));
    chk("run_im_en",   64'(IM_enable),64'(1));
    chk("run_im_we",   64'(IM_write), 64'(0));
    chk("run_fetch2",  64'(im_out),   64'(32'h33));
    cpu_PC = MW'(5);
    #1;
    chk("run_pc5",     64'(PC),       64'(5));
    chk("run_fetch5",  64'(im_out),   64'(0));

    // stray valid in RUN is ignored
    host.in_valid = 1'b1;
    host.in_data  = DW'(32'hBAD);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("run_valid_ready", 64'(host.in_ready), 64'(0));
      chk("run_valid_done",  64'(load_done),     64'(1));
    end
    host.in_valid = 1'b0;
    cpu_IM_read   = 1'b0;
    cpu_IM_enable = 1'b0;

    // restart from RUN, gapped stream, start ignored during LOAD
    pulse_start();
    clear_exp();
    chk("rs_cpu_reset",  64'(cpu_reset),  64'(1));
    chk("rs_load_done",  64'(load_done),  64'(0));
    chk("rs_word_count", 64'(word_count), 64'(0));
    wait_ready();
    mem_check("im_cleared");
    for (int i = 0; i < 5; i++) begin
      send_word(DW'(32'hA0 + i), i == 4);
      if (i < 4) begin
        tick(1);
        chk("gap_no_we", 64'(IM_write), 64'(0));
      end
      if (i == 1) pulse_start();
    end
    tick(1);
    chk("gap_word_count", 64'(word_count), 64'(5));
    chk("gap_load_done",  64'(load_done),  64'(1));
    mem_check("im_prog5");
    cpu_PC = MW'(4); cpu_IM_read = 1'b1; cpu_IM_enable = 1'b1;
    #1;
    chk("run_fetch4", 64'(im_out), 64'(32'hA4));
    cpu_IM_read = 1'b0; cpu_IM_enable = 1'b0;

    // overflow: full memory with no last word
    pulse_start();
    clear_exp();
    wait_ready();
    t0 = cyc;
    for (int i = 0; i < int'(DEPTH); i++) send_word(DW'($urandom), 1'b0);
    chk("throughput",     64'(cyc - t0),       64'(DEPTH));
    chk("err_load_err",   64'(load_err),       64'(1));
    chk("err_ready",      64'(host.in_ready),  64'(0));
    chk("err_cpu_reset",  64'(cpu_reset),      64'(1));
    chk("err_load_done",  64'(load_done),      64'(0));
    chk("err_word_count", 64'(word_count),     64'(DEPTH));
    host.in_valid = 1'b1;
    host.in_data  = DW'(32'hFACE);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("err_hold_ready", 64'(host.in_ready), 64'(0));
      chk("err_hold_err",   64'(load_err),      64'(1));
      chk("err_hold_cpu",   64'(cpu_reset),     64'(1));
    end
    host.in_valid = 1'b0;
    mem_check("im_full");

    // reset after two of four words, then a clean reload
    pulse_start();
    clear_exp();
    chk("err_restart_clr", 64'(load_err), 64'(0));
    send_word(DW'(32'h5000_0001), 1'b0);
    send_word(DW'(32'h5000_0002), 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_cpu_reset",  64'(cpu_reset),      64'(1));
    chk("abort_ready",      64'(host.in_ready),  64'(0));
    chk("abort_word_count", 64'(word_count),     64'(0));
    chk("abort_we",         64'(IM_write),       64'(0));
    tick(1);
    chk("abort_idle_we",    64'(IM_write),       64'(0));
    mem_check("im_abort");
    pulse_start();
    clear_exp();
    for (int i = 0; i < 4; i++) send_word(DW'(32'h7700 + 3 * i), i == 3);
    tick(1);
    chk("reload_word_count", 64'(word_count), 64'(4));
    chk("reload_done",       64'(load_done),  64'(1));
    chk("reload_cpu_reset",  64'(cpu_reset),  64'(0));
    mem_check("im_reload");

    tick(2);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
